uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM encoding, the grant-index width helper and default timing.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StWait = 2'd2
    } state_e;

    // 100 MHz clock, 9600 baud: one 16x-oversampled tick is ~651 clks and a
    // 10-bit frame is ~104167 clks; both defaults carry margin on top.
    localparam int unsigned DefHoldClks  = 1000;
    localparam int unsigned DefFrameClks = 110000;

    function automatic int unsigned grant_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin select: first valid requester after 'last',
// wrapping around; returns a one-hot grant and its index.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned GW  = grant_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [GW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [GW-1:0]   sel
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            if (!found && valid[idx[GW-1:0]]) begin
                found              = 1'b1;
                gnt[idx[GW-1:0]]   = 1'b1;
                sel                = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit path between NREQ byte producers: round-robin grant,
// a timed tx_dte pulse per byte, then a frame-long lockout before the next grant.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned HOLD_CLKS  = DefHoldClks,
    parameter int unsigned FRAME_CLKS = DefFrameClks,
    localparam int unsigned GW        = grant_width(NREQ),
    localparam int unsigned CW        = $clog2(FRAME_CLKS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_dte,
    output logic              busy,
    output logic [GW-1:0]     grant_id
);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic [GW-1:0]   gid_q, gid_d;
    logic [GW-1:0]   last_q, last_d;
    logic            dte_q, dte_d;
    logic [NREQ-1:0] gnt;
    logic [GW-1:0]   sel;
    logic [7:0]      sel_byte;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .valid (req_valid),
        .last  (last_q),
        .gnt   (gnt),
        .sel   (sel)
    );

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) sel_byte = req_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        gid_d     = gid_q;
        last_d    = last_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = gnt;
                if (|gnt) begin
                    data_d  = sel_byte;
                    gid_d   = sel;
                    last_d  = sel;
                    cnt_d   = CW'(HOLD_CLKS - 1);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(FRAME_CLKS - HOLD_CLKS - 1);
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // tx_dte is a dedicated flop so the uart never sees a state-decode glitch.
        dte_d = (state_d == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            gid_q   <= '0;
            last_q  <= GW'(NREQ - 1);
            dte_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            dte_q   <= dte_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_dte   = dte_q;
    assign grant_id = gid_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with NREQ=3, HOLD_CLKS=4, FRAME_CLKS=20.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned FRAME = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_dte;
    logic        busy;
    logic [1:0]  grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ       (NREQ),
        .HOLD_CLKS  (HOLD),
        .FRAME_CLKS (FRAME)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_dte    (tx_dte),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          acc_cnt = 0;
    int unsigned acc_cyc[$];
    bit          post_pend = 1'b0;
    exp_t        post_exp;
    int          dte_run = 0;
    int          dte_pulses = 0;
    int          ready_busy_viol = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every handshake, then checks the
    // registered outputs one cycle later and the tx_dte pulse width.
    always @(negedge clk) begin
        exp_t e;
        int   id;
        if (!rst_n) begin
            post_pend = 1'b0;
            dte_run   = 0;
        end else begin
            if (post_pend) begin
                check("tx_data", tx_data, post_exp.data);
                check("grant_id", grant_id, post_exp.id);
                check("dte_rise", tx_dte, 1);
                post_pend = 1'b0;
            end
            if (busy && req_ready != 3'b000) ready_busy_viol++;
            if (tx_dte) begin
                dte_run++;
            end else if (dte_run != 0) begin
                check("dte_len", dte_run, HOLD);
                dte_pulses++;
                dte_run = 0;
            end
            if ((req_valid & req_ready) != 3'b000) begin
                check("ready_onehot", $countones(req_ready), 1);
                id = 0;
                for (int i = 0; i < 3; i++) if (req_ready[i]) id = i;
                if (sb.size() == 0) begin
                    check("unexpected_acc", id, 7);
                end else begin
                    e = sb.pop_front();
                    check("acc_id", id, e.id);
                    check("acc_data", req_data[8*id +: 8], e.data);
                    post_exp  = e;
                    post_pend = 1'b1;
                end
                acc_cyc.push_back(cyc);
                acc_cnt++;
            end
        end
    end

    // Returns on the posedge that performs acceptance number 'target'.
    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (acc_cnt < target) check("acc_timeout", acc_cnt, target);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        int d0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_dte", tx_dte, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant_id", grant_id, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single byte from requester 1
        @(posedge clk); #2;
        req_valid = 3'b010;
        req_data[15:8] = 8'h30;
        sb.push_back(exp_t'{id: 2'd1, data: 8'h30});
        wait_acc(1); #2 req_valid = '0;
        wait_idle(n);
        check("busy_len", n, FRAME);

        // Reset in the middle of HOLD
        @(posedge clk); #2;
        req_valid = 3'b001;
        req_data[7:0] = 8'h41;
        sb.push_back(exp_t'{id: 2'd0, data: 8'h41});
        wait_acc(2); #2 req_valid = '0;
        repeat (2) @(posedge clk);
        #2 check("hold_before_rst", tx_dte, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_dte", tx_dte, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_grant_id", grant_id, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        req_valid = 3'b001;
        sb.push_back(exp_t'{id: 2'd0, data: 8'h41});
        @(negedge clk);
        check("ready_after_rst", req_ready, 3'b001);
        wait_acc(3); #2 req_valid = '0;

        // Request raised and withdrawn during WAIT
        repeat (8) @(posedge clk);
        #2 req_valid = 3'b100;
        req_data[23:16] = 8'h43;
        repeat (3) @(posedge clk);
        #2 req_valid = '0;
        wait_idle(n);
        repeat (3) @(negedge clk);
        check("withdraw_ready", req_ready, 0);
        check("withdraw_acc", acc_cnt, 3);

        // Grant requester 2 so it becomes the last winner
        @(posedge clk); #2;
        req_valid = 3'b100;
        sb.push_back(exp_t'{id: 2'd2, data: 8'h43});
        wait_acc(4); #2 req_valid = '0;
        wait_idle(n);

        // Wrap priority: last=2 so 0 wins, then 2 wins
        @(posedge clk); #2;
        req_valid = 3'b101;
        req_data  = {8'h43, 8'h42, 8'h41};
        sb.push_back(exp_t'{id: 2'd0, data: 8'h41});
        sb.push_back(exp_t'{id: 2'd2, data: 8'h43});
        wait_acc(5); #2 req_data[7:0] = 8'h44;
        wait_acc(6); #2 req_valid = '0;
        wait_idle(n);

        // Full contention: 0,1,2,0 at exact frame spacing
        @(posedge clk); #2;
        req_valid = 3'b111;
        req_data  = {8'h43, 8'h42, 8'h41};
        sb.push_back(exp_t'{id: 2'd0, data: 8'h41});
        sb.push_back(exp_t'{id: 2'd1, data: 8'h42});
        sb.push_back(exp_t'{id: 2'd2, data: 8'h43});
        sb.push_back(exp_t'{id: 2'd0, data: 8'h41});
        p0 = acc_cyc.size();
        wait_acc(10); #2 req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            check("contend_spacing", acc_cyc[p0+i+1] - acc_cyc[p0+i], FRAME + 1);
        end
        wait_idle(n);

        // Back-to-back single requester with changing data
        @(posedge clk); #2;
        p0 = acc_cyc.size();
        d0 = dte_pulses;
        req_valid = 3'b001;
        req_data[7:0] = 8'hA1;
        sb.push_back(exp_t'{id: 2'd0, data: 8'hA1});
        sb.push_back(exp_t'{id: 2'd0, data: 8'hE0});
        wait_acc(11); #2 req_data[7:0] = 8'hE0;
        wait_acc(12); #2 req_valid = '0;
        wait_idle(n);
        check("b2b_spacing", acc_cyc[p0+1] - acc_cyc[p0], FRAME + 1);
        check("b2b_dte_pulses", dte_pulses - d0, 2);

        check("sb_drained", sb.size(), 0);
        check("ready_while_busy", ready_busy_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
